mux_32_8: RTL and testbench

Transmit-side counterpart of demux_8_32 in the PCI physical-layer datapath. It accepts 32-bit words through a valid/ready handshake and serialises each word into four consecutive 8-bit bytes on clk_4f. A one-word holding buffer allows back-to-back words with no idle cycle between them. Its output feeds demux_8_32 directly in loopback benches.

---
 rtl/pci_phy_pkg.sv | 20 ++
 rtl/mux_32_8_hold.sv | 44 ++++
 rtl/mux_32_8.sv | 99 +++++++++
 tb/tb_mux_32_8.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pci_phy_pkg.sv
// rtl/pci_phy_pkg.sv - shared constants and types for the PCI PHY byte datapath
// Purpose: constants and the byte-index type shared by mux_32_8 and demux_8_32,
//          plus a helper that puts a word into transmit byte order.
// Ports:   none (package).
package pci_phy_pkg;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;
  localparam int         BYTES_PER_WORD    = 4;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  // Reorders a word so the byte to be sent first sits in [31:24]; the shifter
  // then always drains from the top regardless of byte order.
  function automatic logic [31:0] send_order(input logic [31:0] word, input bit msb_first);
    return msb_first ? word : {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/mux_32_8_hold.sv
// rtl/mux_32_8_hold.sv - single-entry word holding register
// Purpose: holds one accepted word that arrived while the shifter was mid-word.
// Ports:   clk_4f, reset_L   - clock, async active-low reset
//          push, push_data   - write a word (entry becomes full)
//          pop               - free the entry (never coincident with push)
//          full, data        - entry occupied / stored word
module mux_32_8_hold (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic [31:0] data
);

  logic        full_q, full_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push) begin
      full_d = 1'b1;
      data_d = push_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/mux_32_8.sv
// rtl/mux_32_8.sv - 32-bit word to 8-bit byte serialiser with one-word buffer
// Purpose: accepts words on a valid/ready handshake and emits four bytes per
//          word on clk_4f, back-to-back when a next word is available.
// Ports:   clk_4f, reset_L      - byte-rate clock, async active-low reset
//          data_in, valid_in    - word input
//          ready_out            - registered, word can be accepted this cycle
//          data_out, valid_out  - registered serial byte output
module mux_32_8
  import pci_phy_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out
);

  logic        busy_q, busy_d;
  byte_idx_t   cnt_q, cnt_d;
  logic [23:0] shreg_q, shreg_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic        boundary;
  logic        load_pend;
  logic        load_in;
  logic        push;
  logic        pend_full;
  logic [31:0] pend_data;
  logic [31:0] load_word;

  assign accept    = valid_in & ready_q;
  assign boundary  = !busy_q || (cnt_q == LAST_BYTE_IDX);
  // The buffered word has priority; a fresh word bypasses only if the buffer is empty.
  assign load_pend = boundary & pend_full;
  assign load_in   = boundary & ~pend_full & accept;
  assign push      = accept & ~load_in;
  assign load_word = send_order(load_pend ? pend_data : data_in, MSB_FIRST);

  mux_32_8_hold u_hold (
    .clk_4f   (clk_4f),
    .reset_L  (reset_L),
    .push     (push),
    .push_data(data_in),
    .pop      (load_pend),
    .full     (pend_full),
    .data     (pend_data)
  );

  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    // Ready mirrors the buffer occupancy after this edge.
    ready_d    = !(push || (pend_full && !load_pend));
    if (!boundary) begin
      data_out_d = shreg_q[23:16];
      shreg_d    = {shreg_q[15:0], 8'h00};
      cnt_d      = byte_idx_t'(cnt_q + 2'd1);
    end else if (load_pend || load_in) begin
      data_out_d = load_word[31:24];
      shreg_d    = load_word[23:0];
      cnt_d      = '0;
      busy_d     = 1'b1;
    end else begin
      data_out_d = IDLE_BYTE;
      cnt_d      = '0;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      data_out_q <= IDLE_BYTE;
      ready_q    <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_out = ready_q;
  assign data_out  = data_out_q;
  assign valid_out = busy_q;

endmodule

// File: tb/tb_mux_32_8.sv
// tb/tb_mux_32_8.sv - scoreboard bench for mux_32_8 in both byte orders
module tb_mux_32_8;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_m, ready_l, valid_m, valid_l;
  logic [7:0]  data_m, data_l;

  always #5 clk_4f = ~clk_4f;

  mux_32_8 #(.IDLE_BYTE(8'h00), .MSB_FIRST(1'b1)) dut_m (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_m), .data_out(data_m), .valid_out(valid_m)
  );

  mux_32_8 #(.IDLE_BYTE(8'h00), .MSB_FIRST(1'b0)) dut_l (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_l), .data_out(data_l), .valid_out(valid_l)
  );

  typedef struct {
    int         edge_n;
    logic [7:0] b_msb;
    logic [7:0] b_lsb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecount = 0;
  int   last_start = -100;
  int   pend_from = -1;
  int   pend_to = -2;

  // Edges counted since reset release; outputs seen at a negedge belong to edge ecount.
  always @(posedge clk_4f) ecount <= reset_L ? ecount + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Reference model: a word starts 4 edges after the previous one or at its
  // own accept edge, whichever is later; a word waiting to start occupies the
  // buffer and holds ready low.
  task automatic model_accept(input int a, input logic [31:0] w);
    int start;
    start = (a > last_start + 4) ? a : last_start + 4;
    if (start > a) begin
      pend_from = a;
      pend_to   = start - 1;
    end
    last_start = start;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{start + i, w[8*(3-i) +: 8], w[8*i +: 8]});
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_start = -100;
    pend_from  = -1;
    pend_to    = -2;
  endtask

  // Called at a negedge: holds the word until ready, returns after the accepting edge.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    valid_in = 1'b1;
    data_in  = w;
    while (!ready_m && n < 40) begin
      @(negedge clk_4f);
      n++;
    end
    if (!ready_m) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      model_accept(ecount + 1, w);
      @(negedge clk_4f);
    end
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    data_in  = $urandom;
    repeat (n) @(negedge clk_4f);
  endtask

  always @(negedge clk_4f) begin : monitor
    logic exp_valid;
    logic exp_ready;
    if (!reset_L) begin
      check("rst_valid_m", valid_m, 0);
      check("rst_data_m", data_m, 0);
      check("rst_ready_m", ready_m, 0);
      check("rst_valid_l", valid_l, 0);
    end else begin
      exp_ready = (ecount >= 1) && !(ecount >= pend_from && ecount <= pend_to);
      exp_valid = (exp_q.size() != 0) && (exp_q[0].edge_n == ecount);
      check("ready_m", ready_m, exp_ready);
      check("ready_l", ready_l, exp_ready);
      check("valid_m", valid_m, exp_valid);
      check("valid_l", valid_l, exp_valid);
      if (exp_valid) begin
        check("byte_msb", data_m, exp_q[0].b_msb);
        check("byte_lsb", data_l, exp_q[0].b_lsb);
        void'(exp_q.pop_front());
      end else begin
        check("idle_m", data_m, 8'h00);
        check("idle_l", data_l, 8'h00);
      end
    end
  end

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk_4f);
    reset_L = 1'b1;
    @(negedge clk_4f);

    send(32'hEEFFFDCC);
    idle(8);

    send(32'hEEFFFDCC);
    send(32'hAA12BB00);
    idle(8);

    send(32'h01234567);
    send(32'h89ABCDEF);
    send(32'h5A5AA5A5);
    idle(10);

    send(32'hEEFFFDCC);
    idle(5);
    send(32'hAA12BB00);
    idle(8);

    send(32'h11223344);
    idle(6);

    send(32'hEEFFFDCC);
    @(negedge clk_4f);
    #2 reset_L = 1'b0;
    #1;
    check("async_valid_m", valid_m, 0);
    check("async_data_m", data_m, 0);
    check("async_ready_m", ready_m, 0);
    check("async_valid_l", valid_l, 0);
    check("async_data_l", data_l, 0);
    check("async_ready_l", ready_l, 0);
    model_reset();
    repeat (2) @(negedge clk_4f);
    reset_L = 1'b1;
    @(negedge clk_4f);
    send(32'h01020304);
    idle(8);

    for (int k = 0; k < 150; k++) begin
      int gap;
      gap = int'($urandom_range(0, 9));
      if (gap > 5) gap = 0;
      send($urandom);
      idle(gap);
    end
    idle(12);
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
